// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcode encodings, flag bit positions and op type for the
//             pipelined ALU.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  // Codes with op[2]=0 keep the legacy 2-bit ALU encoding
  localparam alu_op_t OP_ADD   = 3'b000;
  localparam alu_op_t OP_OR    = 3'b001;
  localparam alu_op_t OP_SUB   = 3'b010;
  localparam alu_op_t OP_XOR   = 3'b011;
  localparam alu_op_t OP_AND   = 3'b100;
  localparam alu_op_t OP_SHL   = 3'b101;
  localparam alu_op_t OP_SHR   = 3'b110;
  localparam alu_op_t OP_PASSA = 3'b111;

  // Positions inside the 4-bit flag vector {N,V,C,Z}
  localparam int FLG_Z = 0;
  localparam int FLG_C = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

  localparam int NUM_FLAGS = 4;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Combinational ALU datapath (a, b, op) -> (result, {N,V,C,Z}).
//             Arithmetic wraps modulo 2^WIDTH; shift amount is b mod WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  alu_op_t              op,
  output logic [WIDTH-1:0]     result,
  output logic [NUM_FLAGS-1:0] flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  // One extra bit on each side captures carry/borrow and the last shifted-out bit
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] shl_ext;
  logic [WIDTH:0] shr_ext;
  logic [SHW-1:0] amt;
  logic           carry;
  logic           ovf;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign amt     = SHW'(b % WIDTH_V);
  assign shl_ext = {1'b0, a} << amt;
  assign shr_ext = {a, 1'b0} >> amt;

  // Operation select; carry/overflow stay 0 for ops that do not define them
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_AND: result = a & b;
      OP_SHL: begin
        result = shl_ext[WIDTH-1:0];
        carry  = shl_ext[WIDTH];
      end
      OP_SHR: begin
        result = shr_ext[WIDTH:1];
        carry  = shr_ext[0];
      end
      default: result = a;
    endcase
  end

  // Flag vector assembly from the selected result
  always_comb begin
    flags        = '0;
    flags[FLG_Z] = (result == '0);
    flags[FLG_C] = carry;
    flags[FLG_V] = ovf;
    flags[FLG_N] = result[WIDTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Two-stage valid/ready pipelined ALU with status flags and a
//             pass-through tag. S1 holds operands, S2 holds results.
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  alu_op_t              in_op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [NUM_FLAGS-1:0] out_flags,
  output logic [TAG_W-1:0]     out_tag
);

  logic                 s1_v;
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;
  alu_op_t              s1_op;
  logic [TAG_W-1:0]     s1_tag;

  logic                 s2_v;
  logic [WIDTH-1:0]     s2_result;
  logic [NUM_FLAGS-1:0] s2_flags;
  logic [TAG_W-1:0]     s2_tag;

  logic [WIDTH-1:0]     core_result;
  logic [NUM_FLAGS-1:0] core_flags;
  logic                 adv1;
  logic                 adv2;

  // A stage may advance when it is empty or the stage after it is moving
  assign adv2     = !s2_v || out_ready;
  assign adv1     = !s1_v || adv2;
  assign in_ready = adv1;

  assign out_valid  = s2_v;
  assign out_result = s2_result;
  assign out_flags  = s2_flags;
  assign out_tag    = s2_tag;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .flags  (core_flags)
  );

  // Stage valid bits; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (adv1) s1_v <= in_valid;
      if (adv2) s2_v <= s1_v;
    end
  end

  // S1 operand capture, only on an accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_op  <= OP_ADD;
      s1_tag <= '0;
    end else if (adv1 && in_valid) begin
      s1_a   <= in_a;
      s1_b   <= in_b;
      s1_op  <= in_op;
      s1_tag <= in_tag;
    end
  end

  // S2 result capture; held while the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_result <= '0;
      s2_flags  <= '0;
      s2_tag    <= '0;
    end else if (adv2 && s1_v) begin
      s2_result <= core_result;
      s2_flags  <= core_flags;
      s2_tag    <= s1_tag;
    end
  end

endmodule
`default_nettype wire
